// File: rtl/kernel_sysid_pkg.sv
// kernel_sysid_pkg
// Shared definitions for the system-ID / uptime register block:
//   - word_t / addr_t   : data word and word-address types
//   - ADDR_*            : register word addresses (6-7 are reserved)
//   - CAPS_*            : bit positions inside the CAPS register
//   - caps_word()       : builds the CAPS read value
package kernel_sysid_pkg;

    typedef logic [31:0] word_t;
    typedef logic [2:0]  addr_t;

    localparam addr_t ADDR_ID        = 3'd0;
    localparam addr_t ADDR_TIMESTAMP = 3'd1;
    localparam addr_t ADDR_SCRATCH   = 3'd2;
    localparam addr_t ADDR_CAPS      = 3'd3;
    localparam addr_t ADDR_UPTIME_LO = 3'd4;
    localparam addr_t ADDR_UPTIME_HI = 3'd5;

    localparam int unsigned CAPS_UPTIME_BIT   = 0;
    localparam int unsigned CAPS_PRESCALE_LSB = 16;

    function automatic word_t caps_word(input logic [15:0] prescale, input logic uptime);
        word_t w;
        w = '0;
        w[CAPS_UPTIME_BIT]              = uptime;
        w[CAPS_PRESCALE_LSB +: 16]      = prescale;
        return w;
    endfunction

endpackage

// File: rtl/kernel_sysid_uptime.sv
// kernel_sysid_uptime
// 64-bit free-running uptime counter advanced once every PRESCALE clocks,
// with a high-word snapshot register so a LO-then-HI read pair is coherent.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_ni  : asynchronous active-low reset
//   clear_i : clears prescaler, counter and snapshot on the next edge
//   snap_i  : latch the live high word into the snapshot
//   lo_o    : live low word of the counter
//   hi_o    : snapshot of the high word
module kernel_sysid_uptime
    import kernel_sysid_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  clear_i,
    input  logic  snap_i,
    output word_t lo_o,
    output word_t hi_o
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_q, pre_d;
    logic [63:0] cnt_q, cnt_d;
    word_t       snap_q, snap_d;

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        snap_d = snap_q;
        if (clear_i) begin
            // Clear has priority over a coincident tick, wrap or snapshot.
            pre_d  = '0;
            cnt_d  = '0;
            snap_d = '0;
        end else begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                cnt_d = cnt_q + 64'd1;
            end else begin
                pre_d = pre_q + 16'd1;
            end
            if (snap_i) begin
                snap_d = cnt_q[63:32];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    assign lo_o = cnt_q[31:0];
    assign hi_o = snap_q;

endmodule

// File: rtl/kernel_sysid_ext.sv
// kernel_sysid_ext
// Avalon-MM slave exposing system ID, build timestamp, a scratch register,
// a capabilities word and (optionally) a 64-bit uptime counter.
// Optional feature macro: KERNEL_SYSID_UPTIME_EN (uptime counter at words 4/5).
// Ports:
//   clock         : clock (rising edge)
//   reset_n       : asynchronous active-low reset
//   address       : word address
//   read / write  : single-cycle strobes
//   writedata     : write data
//   readdata      : registered read data, held between reads
//   readdatavalid : one-cycle pulse, one cycle after read
module kernel_sysid_ext
    import kernel_sysid_pkg::*;
#(
    parameter logic [31:0] SYSID_ID        = '0,
    parameter logic [31:0] SYSID_TIMESTAMP = '0,
    parameter int unsigned PRESCALE        = 1,
    parameter logic [31:0] SCRATCH_RST     = '0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

`ifdef KERNEL_SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
`else
    localparam logic UPTIME_PRESENT = 1'b0;
`endif

    localparam word_t CAPS = caps_word(16'(PRESCALE), UPTIME_PRESENT);

    word_t scratch_q, scratch_d;
    word_t rdata_q, rdata_d;
    logic  rvalid_q, rvalid_d;
    word_t rd_mux;

`ifdef KERNEL_SYSID_UPTIME_EN
    logic  up_clear, up_snap;
    word_t up_lo, up_hi;

    assign up_clear = write && (address == ADDR_UPTIME_LO);
    assign up_snap  = read  && (address == ADDR_UPTIME_LO);

    kernel_sysid_uptime #(
        .PRESCALE (PRESCALE)
    ) u_uptime (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .clear_i (up_clear),
        .snap_i  (up_snap),
        .lo_o    (up_lo),
        .hi_o    (up_hi)
    );
`endif

    // Mux reads current-cycle state, so a coincident write is not yet visible.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:        rd_mux = SYSID_ID;
            ADDR_TIMESTAMP: rd_mux = SYSID_TIMESTAMP;
            ADDR_SCRATCH:   rd_mux = scratch_q;
            ADDR_CAPS:      rd_mux = CAPS;
`ifdef KERNEL_SYSID_UPTIME_EN
            ADDR_UPTIME_LO: rd_mux = up_lo;
            ADDR_UPTIME_HI: rd_mux = up_hi;
`endif
            default:        rd_mux = '0;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        rdata_d   = rdata_q;
        rvalid_d  = read;
        if (write && (address == ADDR_SCRATCH)) begin
            scratch_d = writedata;
        end
        if (read) begin
            rdata_d = rd_mux;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= SCRATCH_RST;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_kernel_sysid_ext.sv
// tb_kernel_sysid_ext
// Directed bench for kernel_sysid_ext. Two instances share the bus inputs:
// dut1 (PRESCALE=1) and dut4 (PRESCALE=4). Works with or without
// KERNEL_SYSID_UPTIME_EN defined.
module tb_kernel_sysid_ext;

    localparam logic [31:0] ID  = 32'h5B67_0779;
    localparam logic [31:0] TS  = 32'h2024_0115;
    localparam logic [31:0] SRST = 32'hA5A5_0001;

`ifdef KERNEL_SYSID_UPTIME_EN
    localparam logic [31:0] UP = 32'd1;
`else
    localparam logic [31:0] UP = 32'd0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] rd1, rd4;
    logic        rv1, rv4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    kernel_sysid_ext #(
        .SYSID_ID        (ID),
        .SYSID_TIMESTAMP (TS),
        .PRESCALE        (1),
        .SCRATCH_RST     (SRST)
    ) dut1 (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (rd1),
        .readdatavalid (rv1)
    );

    kernel_sysid_ext #(
        .SYSID_ID        (ID),
        .SYSID_TIMESTAMP (TS),
        .PRESCALE        (4),
        .SCRATCH_RST     (SRST)
    ) dut4 (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (rd4),
        .readdatavalid (rv4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a);
        @(negedge clock);
        address = a;
        read    = 1'b1;
        @(posedge clock);
        #1 read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(posedge clock);
        #1 write = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;

        // Reset state
        #22;
        check("reset_rdata", rd1, 32'h0);
        check("reset_valid", {31'b0, rv1}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // ID read: valid exactly one cycle, data held afterwards
        rd(3'd0);
        check("id_valid", {31'b0, rv1}, 32'd1);
        check("id_data", rd1, ID);
        @(posedge clock); #1;
        check("id_valid_drop", {31'b0, rv1}, 32'd0);
        check("id_hold", rd1, ID);

        rd(3'd1);
        check("timestamp", rd1, TS);
        rd(3'd2);
        check("scratch_rst", rd1, SRST);

        wr(3'd2, 32'hDEAD_BEEF);
        rd(3'd2);
        check("scratch_wr", rd1, 32'hDEAD_BEEF);

        rd(3'd3);
        check("caps_p1", rd1, 32'h0001_0000 | UP);
        check("caps_p4", rd4, 32'h0004_0000 | UP);

        rd(3'd6);
        check("reserved6", rd1, 32'h0);
        rd(3'd7);
        check("reserved7", rd1, 32'h0);

        // Writes to read-only words are ignored
        wr(3'd0, 32'h1234_5678);
        wr(3'd1, 32'h8765_4321);
        wr(3'd3, 32'hFFFF_FFFF);
        rd(3'd0);
        check("id_ro", rd1, ID);
        rd(3'd1);
        check("ts_ro", rd1, TS);
        rd(3'd3);
        check("caps_ro", rd1, 32'h0001_0000 | UP);

        // Coincident read+write returns the pre-write value
        wr(3'd2, 32'd5);
        @(negedge clock);
        address   = 3'd2;
        writedata = 32'd9;
        read      = 1'b1;
        write     = 1'b1;
        @(posedge clock);
        #1 read = 1'b0; write = 1'b0;
        check("rw_old", rd1, 32'd5);
        rd(3'd2);
        check("rw_new", rd1, 32'd9);

`ifdef KERNEL_SYSID_UPTIME_EN
        // Clear, then 40 edges: dut1 counts 40, dut4 counts 40/4 = 10
        wr(3'd4, 32'h0);
        repeat (40) @(posedge clock);
        rd(3'd4);
        check("uptime_p1", rd1, 32'd40);
        check("uptime_p4", rd4, 32'd10);
        rd(3'd5);
        check("uphi_p4", rd4, 32'd0);

        // Low-word carry: snapshot must come from the LO read cycle
        @(negedge clock);
        force dut1.u_uptime.cnt_q = 64'h0000_0000_FFFF_FFFF;
        address = 3'd4;
        read    = 1'b1;
        @(posedge clock);
        #1 read = 1'b0;
        release dut1.u_uptime.cnt_q;
        check("carry_lo", rd1, 32'hFFFF_FFFF);
        rd(3'd5);
        check("carry_snap0", rd1, 32'd0);
        rd(3'd4);
        check("carry_lo2", rd1, 32'd0);
        rd(3'd5);
        check("carry_snap1", rd1, 32'd1);

        // Write to LO clears counter and snapshot
        wr(3'd4, 32'hFFFF_FFFF);
        rd(3'd5);
        check("clear_snap", rd1, 32'd0);
        rd(3'd4);
        check("clear_lo", rd1, 32'd1);
`else
        wr(3'd4, 32'h0000_1234);
        rd(3'd4);
        check("noup_lo", rd1, 32'h0);
        rd(3'd5);
        check("noup_hi", rd1, 32'h0);
`endif

        // Reset during a read: no response for that read
        @(negedge clock);
        address = 3'd0;
        read    = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clock);
        #1 read = 1'b0;
        check("midrst_valid", {31'b0, rv1}, 32'd0);
        check("midrst_rdata", rd1, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("postrst_valid", {31'b0, rv1}, 32'd0);
        rd(3'd2);
        check("scratch_after_rst", rd1, SRST);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_sysid_ext.md
KERNEL_SYSID_EXT -- requirements
Module: kernel_sysid_ext

Interface
REQ-001 Parameter SYSID_ID, default 0: 32-bit system identifier returned at word 0.
REQ-002 Parameter SYSID_TIMESTAMP, default 0: 32-bit build timestamp returned at word 1.
REQ-003 Parameter PRESCALE, default 1, legal range 1..65535: clock cycles per uptime tick.
REQ-004 Parameter SCRATCH_RST, default 0: 32-bit reset value of the scratch register.
REQ-005 clock  input  1  single clock; all state is on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 address  input  3  Avalon-MM word address.
REQ-008 read  input  1  read strobe, single cycle per transfer.
REQ-009 write  input  1  write strobe, single cycle per transfer.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.
REQ-012 readdatavalid  output  1  high for exactly one cycle when readdata is valid.

Function
REQ-013 The address map SHALL be: 0 ID (RO), 1 TIMESTAMP (RO), 2 SCRATCH (RW), 3 CAPS (RO), 4 UPTIME_LO (RO, write = clear), 5 UPTIME_HI snapshot (RO), 6-7 reserved.
REQ-014 CAPS SHALL read as: bit0 = uptime present, bits[31:16] = PRESCALE, all other bits 0.
REQ-015 Read latency SHALL be fixed at 1: read asserted in cycle N gives readdatavalid=1 with readdata in cycle N+1; no waitrequest.
REQ-016 readdata SHALL hold its last value while readdatavalid=0.
REQ-017 Reserved addresses SHALL read 0; writes to RO and reserved addresses SHALL be ignored.
REQ-018 The uptime counter SHALL be 64 bits and increment by 1 each time the 16-bit prescaler reaches PRESCALE-1; the prescaler then returns to 0.
REQ-019 With PRESCALE=1, the counter SHALL increment every cycle.
REQ-020 The counter SHALL wrap from 2^64-1 to 0 with no flag.
REQ-021 A read of UPTIME_LO SHALL return the live low word and, in the same cycle, latch the live high word into the snapshot register.
REQ-022 A read of UPTIME_HI SHALL return the snapshot, not the live high word.
REQ-023 A write to UPTIME_LO (any data) SHALL clear the counter, prescaler and snapshot on the next edge; clear wins over a coincident tick or wrap.
REQ-024 When read and write are both asserted, the write SHALL take effect and the read SHALL return the pre-write value.

Reset
REQ-025 On reset_n low: readdata=0, readdatavalid=0, SCRATCH=SCRATCH_RST, counter=0, prescaler=0, snapshot=0.
REQ-026 A reset mid-transfer SHALL drop any pending readdatavalid; no response is issued for a read accepted in the cycle reset asserts.
REQ-027 Reset release SHALL be usable directly; counting starts on the first edge with reset_n high.

Configuration
REQ-028 Macro KERNEL_SYSID_UPTIME_EN defined: uptime counter, prescaler and snapshot are present as in REQ-018..023, and CAPS bit0=1.
REQ-029 Macro KERNEL_SYSID_UPTIME_EN undefined: no counter logic, addresses 4-5 read 0, writes to them are ignored, and CAPS bit0=0; all other behaviour is unchanged.

Structure
REQ-030 Package kernel_sysid_pkg SHALL hold the address constants (ADDR_ID..ADDR_UPTIME_HI), CAPS bit positions and the 32-bit data word typedef.
REQ-031 The prescaler, counter and snapshot SHALL live in sub-module kernel_sysid_uptime, instantiated only under KERNEL_SYSID_UPTIME_EN.

Verification
REQ-032 SYSID_ID=32'h5B670779, read addr 0 in cycle N -> readdata=32'h5B670779 with readdatavalid=1 in N+1 only.
REQ-033 Write 32'hDEADBEEF to addr 2, read addr 2 -> 32'hDEADBEEF; assert reset, read addr 2 -> SCRATCH_RST.
REQ-034 PRESCALE=4, macro defined, clear via addr 4, wait 40 cycles, read addr 4 -> 10 (+/-1 for read alignment); read addr 5 -> 0.
REQ-035 Force counter to 64'h0000_0000_FFFF_FFFF, PRESCALE=1, read addr 4 then addr 5 -> high snapshot 0, not 1; next addr 4/addr 5 pair -> high word 1.
REQ-036 Coincident read+write on addr 2 (old 5, new 9) -> readdata 5, then a subsequent read returns 9; write to addr 0 -> ID unchanged.
REQ-037 Macro undefined: read addr 3 -> bit0=0 and bits[31:16]=PRESCALE; reads of addr 4, 5, 6 and 7 -> 0.
